// File: rtl/avr_tick_scheduler.sv
// Round-robin tick scheduler that shares one tick/pin-sync path between NCORES AVR cores.
// Per-core dividers raise tick requests; a command FSM runs, halts and single-steps cores.
module avr_tick_scheduler #(
  parameter int unsigned NCORES = 4,
  parameter int unsigned DIVW   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NCORES*DIVW-1:0]      div_cfg,
  input  logic                        cfg_load,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [NCORES-1:0]           cmd_mask,
  output logic                        cmd_done,
  output logic                        cmd_err,
  output logic [NCORES-1:0]           tick,
  output logic                        sync_strobe,
  output logic [$clog2(NCORES)-1:0]   sync_core,
  output logic [NCORES-1:0]           running,
  output logic [NCORES-1:0]           overrun
);

  localparam int unsigned IW = $clog2(NCORES);

  localparam logic [1:0] OpRun  = 2'b00;
  localparam logic [1:0] OpHalt = 2'b01;
  localparam logic [1:0] OpStep = 2'b10;

  typedef enum logic [1:0] {StIdle, StDrain, StSwait, StDone} state_e;

  logic [DIVW-1:0]   div_q [NCORES];
  logic [DIVW-1:0]   div_d [NCORES];
  logic [DIVW-1:0]   cnt_q [NCORES];
  logic [DIVW-1:0]   cnt_d [NCORES];
  logic [NCORES-1:0] pend_q, pend_d, pend_eff;
  logic [NCORES-1:0] step_q, step_d;
  logic [NCORES-1:0] running_q, running_d;
  logic [NCORES-1:0] overrun_q, overrun_d;
  logic [NCORES-1:0] tick_q;
  logic [NCORES-1:0] active, expire;
  logic [NCORES-1:0] run_set, run_clr, step_set, step_clr, step_after;
  logic [IW-1:0]     rr_ptr_q, rr_nxt, gnt_idx, gnt_idx_q, sync_core_q;
  logic [NCORES-1:0] gnt_oh;
  logic              gnt_valid, sync_strobe_q;

  state_e            state_q;
  logic [NCORES-1:0] mask_q;
  logic              err_lat_q, cmd_ready_q, cmd_done_q, cmd_err_q;
  logic              accept;

  assign accept = cmd_valid & cmd_ready_q;

  // Command side effects on run/step bits happen in the accept cycle.
  always_comb begin
    run_set  = '0;
    run_clr  = '0;
    step_set = '0;
    step_clr = '0;
    if (accept) begin
      case (cmd_op)
        OpRun: begin
          run_set  = cmd_mask;
          step_clr = cmd_mask;
        end
        OpHalt:  run_clr  = cmd_mask;
        OpStep:  step_set = cmd_mask & ~running_q;
        default: ;
      endcase
    end
  end

  assign step_after = (step_q | (cmd_mask & ~running_q)) & cmd_mask;

  // Round-robin search of pending requests starting at rr_ptr.
  always_comb begin : arb
    logic [IW:0] idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NCORES; k++) begin
      idx = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (idx >= (IW+1)'(NCORES)) idx = idx - (IW+1)'(NCORES);
      if (!gnt_valid && pend_q[idx[IW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx[IW-1:0];
      end
    end
    gnt_oh = '0;
    if (gnt_valid) gnt_oh[gnt_idx] = 1'b1;
    rr_nxt = (gnt_idx == IW'(NCORES - 1)) ? '0 : gnt_idx + IW'(1);
  end

  // A stepping core stops counting once its single request is pending.
  always_comb begin
    active = '0;
    expire = '0;
    for (int i = 0; i < NCORES; i++) begin
      active[i] = running_q[i] | (step_q[i] & ~pend_q[i]);
      expire[i] = active[i] & (cnt_q[i] == '0) & ~cfg_load;
      div_d[i]  = cfg_load ? div_cfg[i*DIVW +: DIVW] : div_q[i];
      if (cfg_load)       cnt_d[i] = div_cfg[i*DIVW +: DIVW];
      else if (active[i]) cnt_d[i] = (cnt_q[i] == '0) ? div_q[i] : cnt_q[i] - DIVW'(1);
      else                cnt_d[i] = cnt_q[i];
    end
    // A request granted this cycle frees its slot for a same-cycle expiry.
    pend_eff  = pend_q & ~gnt_oh;
    pend_d    = pend_eff | expire;
    overrun_d = overrun_q | (pend_eff & expire);
    running_d = (running_q & ~run_clr) | run_set;
    step_d    = ((step_q & ~gnt_oh) | step_set) & ~step_clr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCORES; i++) begin
        div_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      pend_q        <= '0;
      step_q        <= '0;
      running_q     <= '0;
      overrun_q     <= '0;
      tick_q        <= '0;
      rr_ptr_q      <= '0;
      gnt_idx_q     <= '0;
      sync_strobe_q <= 1'b0;
      sync_core_q   <= '0;
    end else begin
      for (int i = 0; i < NCORES; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      pend_q        <= pend_d;
      step_q        <= step_d;
      running_q     <= running_d;
      overrun_q     <= overrun_d;
      tick_q        <= gnt_oh;
      gnt_idx_q     <= gnt_idx;
      if (gnt_valid) rr_ptr_q <= rr_nxt;
      sync_strobe_q <= |tick_q;
      sync_core_q   <= (|tick_q) ? gnt_idx_q : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      err_lat_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      cmd_done_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      cmd_done_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            cmd_ready_q <= 1'b0;
            mask_q      <= cmd_mask;
            err_lat_q   <= 1'b0;
            case (cmd_op)
              OpRun:   state_q <= StDone;
              OpHalt:  state_q <= StDrain;
              OpStep:  state_q <= (step_after == '0) ? StDone : StSwait;
              default: begin
                err_lat_q <= 1'b1;
                state_q   <= StDone;
              end
            endcase
          end
        end
        StDrain: if ((pend_q & mask_q) == '0) state_q <= StDone;
        StSwait: if ((step_q & mask_q) == '0) state_q <= StDone;
        StDone: begin
          cmd_done_q  <= 1'b1;
          cmd_err_q   <= err_lat_q;
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign cmd_done    = cmd_done_q;
  assign cmd_err     = cmd_err_q;
  assign tick        = tick_q;
  assign sync_strobe = sync_strobe_q;
  assign sync_core   = sync_core_q;
  assign running     = running_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_avr_tick_scheduler.sv
// Directed bench for avr_tick_scheduler: reset, dividers, contention, step, halt drain,
// illegal op and reset in mid-command.
module tb_avr_tick_scheduler;

  localparam int NC = 4;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NC*DW-1:0] div_cfg;
  logic             cfg_load;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [NC-1:0]    cmd_mask;
  logic             cmd_done;
  logic             cmd_err;
  logic [NC-1:0]    tick;
  logic             sync_strobe;
  logic [1:0]       sync_core;
  logic [NC-1:0]    running;
  logic [NC-1:0]    overrun;

  int checks   = 0;
  int failures = 0;

  avr_tick_scheduler #(.NCORES(NC), .DIVW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .div_cfg     (div_cfg),
    .cfg_load    (cfg_load),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_mask    (cmd_mask),
    .cmd_done    (cmd_done),
    .cmd_err     (cmd_err),
    .tick        (tick),
    .sync_strobe (sync_strobe),
    .sync_core   (sync_core),
    .running     (running),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh_idx(input logic [NC-1:0] v);
    logic [1:0] r = '0;
    for (int i = 0; i < NC; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cmd_valid = 1'b0; cfg_load = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_div(input logic [NC*DW-1:0] d);
    @(negedge clk);
    div_cfg = d; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  // Returns 1ns after the accepting edge; mask is then scrambled to prove it was latched.
  task automatic send_cmd(input string tag, input logic [1:0] op, input logic [NC-1:0] mask);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_mask = mask;
    for (int k = 0; k < 50 && !cmd_ready; k++) @(negedge clk);
    chk({tag, "_accept"}, 32'(cmd_ready), 32'd1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_mask = ~mask; cmd_op = 2'b00;
  endtask

  initial begin : main
    int c0, c3, c1, tick_n, done_n, t0_cnt, t0_late, err_at_done, t1_cnt, cnt_after;
    logic [NC-1:0] prev;
    bit done_seen;

    // T1: reset with cmd_valid held high
    rst_n = 1'b0; div_cfg = '0; cfg_load = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_mask = 4'hF;
    repeat (2) @(negedge clk);
    chk("t1_tick", 32'(tick), 32'h0);
    chk("t1_ready", 32'(cmd_ready), 32'h1);
    chk("t1_running", 32'(running), 32'h0);
    chk("t1_overrun", 32'(overrun), 32'h0);
    chk("t1_done", 32'(cmd_done), 32'h0);
    chk("t1_sync", 32'(sync_strobe), 32'h0);
    cmd_valid = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_no_accept", 32'(running), 32'h0);

    // T2: core0 div 1, core3 div 3; steady pattern per 4 cycles: tick3, tick0, tick0, idle
    load_div({8'd3, 8'd0, 8'd0, 8'd1});
    send_cmd("t2_run", 2'b00, 4'b1001);
    repeat (12) @(negedge clk);
    prev = tick; c0 = 0; c3 = 0; c1 = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      chk("t2_sync_strobe", 32'(sync_strobe), 32'(|prev));
      if (|prev) chk("t2_sync_core", 32'(sync_core), 32'(oh_idx(prev)));
      if (tick[0]) c0++;
      if (tick[3]) c3++;
      if (tick[1] || tick[2]) c1++;
      prev = tick;
    end
    chk("t2_core0_ticks", 32'(c0), 32'd8);
    chk("t2_core3_ticks", 32'(c3), 32'd4);
    chk("t2_other_ticks", 32'(c1), 32'd0);
    chk("t2_overrun", 32'(overrun), 32'h0);
    chk("t2_running", 32'(running), 32'h9);

    // T3: four div=0 cores share bandwidth
    do_reset();
    load_div('0);
    send_cmd("t3_run", 2'b00, 4'hF);
    for (int k = 0; k < 10 && tick == '0; k++) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk("t3_tick_seq", 32'(tick), 32'(4'b0001 << (k % 4)));
      @(negedge clk);
    end
    chk("t3_overrun", 32'(overrun), 32'hF);

    // T4: step core0 with div 5; step set at accept edge, expiry 6 edges on, tick 1 later
    do_reset();
    load_div(32'h0000_0005);
    send_cmd("t4_step", 2'b10, 4'b0001);
    tick_n = 0; done_n = 0; t0_cnt = 0; err_at_done = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (tick[0]) begin
        t0_cnt++;
        if (tick_n == 0) tick_n = n;
      end
      if (cmd_done && done_n == 0) begin
        done_n = n;
        err_at_done = 32'(cmd_err);
      end
    end
    chk("t4_tick_cycle", 32'(tick_n), 32'd8);
    chk("t4_tick_count", 32'(t0_cnt), 32'd1);
    chk("t4_done_cycle", 32'(done_n), 32'd10);
    chk("t4_err", 32'(err_at_done), 32'd0);
    chk("t4_running", 32'(running), 32'h0);

    // T5: halt core0 while cores 0 and 1 run at div 0
    do_reset();
    load_div('0);
    send_cmd("t5_run", 2'b00, 4'b0011);
    repeat (6) @(negedge clk);
    send_cmd("t5_halt", 2'b01, 4'b0001);
    done_seen = 1'b0; t0_late = 0; t1_cnt = 0; cnt_after = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) chk("t5_ready_low", 32'(cmd_ready), 32'd0);
      if (done_seen) begin
        cnt_after++;
        if (tick[0]) t0_late++;
        if (tick[1]) t1_cnt++;
      end
      if (cmd_done) done_seen = 1'b1;
    end
    chk("t5_done_seen", 32'(done_seen), 32'd1);
    chk("t5_tick0_after_done", 32'(t0_late), 32'd0);
    chk("t5_tick1_after_done", 32'(t1_cnt), 32'(cnt_after));
    chk("t5_running", 32'(running), 32'h2);

    // T6: illegal op; done/err two cycles after the accept cycle
    send_cmd("t6_ill", 2'b11, 4'hF);
    @(negedge clk);
    chk("t6_done_n1", 32'(cmd_done), 32'd0);
    @(negedge clk);
    chk("t6_done_n2", 32'(cmd_done), 32'd1);
    chk("t6_err_n2", 32'(cmd_err), 32'd1);
    chk("t6_ready_n2", 32'(cmd_ready), 32'd1);
    chk("t6_running", 32'(running), 32'h2);
    @(negedge clk);
    chk("t6_done_n3", 32'(cmd_done), 32'd0);

    // T7: reset during a long step aborts without cmd_done
    load_div(32'h0000_00C8);
    send_cmd("t7_step", 2'b10, 4'b0001);
    repeat (3) @(negedge clk);
    chk("t7_busy", 32'(cmd_ready), 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_n = 0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (cmd_done) done_n++;
    end
    chk("t7_no_done", 32'(done_n), 32'd0);
    chk("t7_ready", 32'(cmd_ready), 32'd1);
    chk("t7_running", 32'(running), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
